// File: rtl/dice_lights_pkg.sv
// Shared types, bus patterns and segment table for the dice/lights receiver.
// Imported by dice_lights_decoder and traffic_seq_checker.
package dice_lights_pkg;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        RED     = 3'd1,
        RED_AMB = 3'd2,
        GREEN   = 3'd3,
        AMBER   = 3'd4
    } light_state_t;

    // Lights are packed {red,amber,green}
    localparam logic [2:0] PAT_RED     = 3'b100;
    localparam logic [2:0] PAT_RED_AMB = 3'b110;
    localparam logic [2:0] PAT_GREEN   = 3'b001;
    localparam logic [2:0] PAT_AMBER   = 3'b010;

    // Active-high {g,f,e,d,c,b,a}; anything outside 1..6 is blank
    function automatic logic [6:0] seg7_lut(input logic [2:0] d);
        logic [6:0] s;
        case (d)
            3'd1:    s = 7'b0000110;
            3'd2:    s = 7'b1011011;
            3'd3:    s = 7'b1001111;
            3'd4:    s = 7'b1100110;
            3'd5:    s = 7'b1101101;
            3'd6:    s = 7'b1111101;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/traffic_seq_checker.sv
// Lights phase tracker with sticky legality flag.
// Ports: clk, rst(n), en, force_sync, pat, clr in; state, seq_err out.
module traffic_seq_checker
    import dice_lights_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         force_sync,
    input  logic [2:0]   pat,
    input  logic         clr,
    output light_state_t state,
    output logic         seq_err
);

    light_state_t st_q, st_d;
    light_state_t pat_ph, succ;
    logic         pat_ok;
    logic         err_set;
    logic         err_d;

    always_comb begin
        pat_ok = 1'b1;
        pat_ph = SYNC;
        case (pat)
            PAT_RED:     pat_ph = RED;
            PAT_RED_AMB: pat_ph = RED_AMB;
            PAT_GREEN:   pat_ph = GREEN;
            PAT_AMBER:   pat_ph = AMBER;
            default:     pat_ok = 1'b0;
        endcase
    end

    always_comb begin
        succ = SYNC;
        case (st_q)
            RED:     succ = RED_AMB;
            RED_AMB: succ = GREEN;
            GREEN:   succ = AMBER;
            AMBER:   succ = RED;
            default: succ = SYNC;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        err_set = 1'b0;
        if (force_sync) begin
            st_d = SYNC;
        end else if (en) begin
            if (!pat_ok) begin
                err_set = 1'b1;
                st_d    = SYNC;
            end else if (st_q == SYNC) begin
                st_d = pat_ph;
            end else if (pat_ph == succ) begin
                st_d = pat_ph;
            end else if (pat_ph != st_q) begin
                // legal pattern out of order: drop to SYNC, resync next cycle
                err_set = 1'b1;
                st_d    = SYNC;
            end
        end
        err_d = clr ? 1'b0 : (seq_err | err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= SYNC;
            seq_err <= 1'b0;
        end else begin
            st_q    <= st_d;
            seq_err <= err_d;
        end
    end

    assign state = st_q;

endmodule

// File: rtl/dice_lights_decoder.sv
// Receiver for the shared 3-bit dice/lights bus: debounced dice + lights tracker.
// Ports: clk, rst(n), sel, result, clr in; dice_val, seg, throw_count, dice_err, light_state, seq_err out.
module dice_lights_decoder #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned STABLE_CYC     = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [2:0]       result,
    input  logic             clr,
    output logic [2:0]       dice_val,
    output logic [6:0]       seg,
    output logic [CNT_W-1:0] throw_count,
    output logic             dice_err,
    output logic [2:0]       light_state,
    output logic             seq_err
);
    import dice_lights_pkg::*;

    localparam int unsigned    STW      = $clog2(STABLE_CYC + 1);
    localparam logic [STW-1:0] STAB_MAX = STW'(STABLE_CYC);
    localparam logic [STW-1:0] STAB_PRE = STW'(STABLE_CYC - 1);
    localparam bit             ONE_CYC  = (STABLE_CYC == 1);

    logic           sel_q, sel_p;
    logic           vld_q, vld_p;
    logic [2:0]     res_q;
    logic [2:0]     dprev;
    logic [STW-1:0] stab_cnt;

    logic blank;
    logic dice_en, lite_en;
    logic force_sync, stab_rst;
    logic changed, settle, good;
    logic [6:0] seg_raw;
    light_state_t ls;

    // vld_q marks the first real sample after reset; vld_p keeps that
    // first sample from being treated as a sel switch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 1'b0;
            res_q <= 3'd0;
            vld_q <= 1'b0;
            sel_p <= 1'b0;
            vld_p <= 1'b0;
        end else begin
            sel_q <= sel;
            res_q <= result;
            vld_q <= 1'b1;
            sel_p <= sel_q;
            vld_p <= vld_q;
        end
    end

    always_comb begin
        blank      = vld_p & (sel_q ^ sel_p);
        dice_en    = vld_q & ~sel_q & ~blank;
        lite_en    = vld_q & sel_q & ~blank;
        force_sync = vld_q & blank & sel_q;
        stab_rst   = vld_q & blank & ~sel_q;
        changed    = (res_q != dprev);
        good       = (|res_q) & ~(&res_q);
        // settle exactly once, on the step into STABLE_CYC
        settle     = dice_en &
                     (changed ? ONE_CYC : (stab_cnt == STAB_PRE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dprev    <= 3'd0;
            stab_cnt <= '0;
        end else if (stab_rst) begin
            stab_cnt <= '0;
        end else if (dice_en) begin
            dprev <= res_q;
            if (changed)
                stab_cnt <= STW'(1);
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + STW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dice_val    <= 3'd0;
            dice_err    <= 1'b0;
            throw_count <= '0;
        end else begin
            dice_err <= settle & ~good;
            if (settle && good)
                dice_val <= res_q;
            if (clr)
                throw_count <= '0;
            else if (settle && good && !(&throw_count))
                throw_count <= throw_count + CNT_W'(1);
        end
    end

    assign seg_raw = seg7_lut(dice_val);
    assign seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

    traffic_seq_checker u_seq (
        .clk        (clk),
        .rst        (rst),
        .en         (lite_en),
        .force_sync (force_sync),
        .pat        (res_q),
        .clr        (clr),
        .state      (ls),
        .seq_err    (seq_err)
    );

    assign light_state = ls;

endmodule

// File: tb/tb_dice_lights_decoder.sv
// Self-checking bench for dice_lights_decoder against a behavioural model.
// Drives at negedge, checks at negedge after each rising edge.
module tb_dice_lights_decoder;

    localparam int CNT_W  = 8;
    localparam int STABLE = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sel = 1'b0;
    logic [2:0]       result = 3'd0;
    logic             clr = 1'b0;
    logic [2:0]       dice_val;
    logic [6:0]       seg;
    logic [CNT_W-1:0] throw_count;
    logic             dice_err;
    logic [2:0]       light_state;
    logic             seq_err;

    dice_lights_decoder #(
        .CNT_W(CNT_W), .STABLE_CYC(STABLE), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .result(result), .clr(clr),
        .dice_val(dice_val), .seg(seg), .throw_count(throw_count),
        .dice_err(dice_err), .light_state(light_state), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [8] = '{7'b0000000, 7'b0000110, 7'b1011011,
                                7'b1001111, 7'b1100110, 7'b1101101,
                                7'b1111101, 7'b0000000};
    logic [2:0] lpat [1:4] = '{3'b100, 3'b110, 3'b001, 3'b010};

    // model: p_* is the sample waiting to be decoded, h_* the last decoded sel
    logic       p_vld, p_sel, h_vld, h_sel;
    logic [2:0] p_res, last;
    int         run;
    logic [2:0] e_val;
    int         e_cnt, e_state;
    logic       e_err, e_seq;

    wire [22:0] dut_bus = {dice_val, seg, throw_count, dice_err,
                           light_state, seq_err};

    function automatic logic [22:0] exp_bus();
        logic [CNT_W-1:0] c;
        logic [2:0] s;
        c = e_cnt[CNT_W-1:0];
        s = e_state[2:0];
        return {e_val, seg_tab[e_val], c, e_err, s, e_seq};
    endfunction

    task automatic model_reset();
        p_vld = 0; p_sel = 0; p_res = 0; h_vld = 0; h_sel = 0;
        last = 0; run = 0;
        e_val = 0; e_cnt = 0; e_state = 0; e_err = 0; e_seq = 0;
    endtask

    task automatic model_edge();
        bit blank, settle;
        int idx, old;
        if (p_vld) begin
            blank = h_vld && (p_sel != h_sel);
            e_err = 0;
            if (!p_sel) begin
                if (blank) run = 0;
                else begin
                    old = run;
                    if (p_res == last) run = (run < STABLE) ? run + 1 : STABLE;
                    else run = 1;
                    settle = (run == STABLE) && ((p_res != last) || old < STABLE);
                    last = p_res;
                    if (settle) begin
                        if (p_res == 0 || p_res == 7) e_err = 1;
                        else begin
                            e_val = p_res;
                            if (e_cnt < CMAX) e_cnt++;
                        end
                    end
                end
            end else if (blank) begin
                e_state = 0;
            end else begin
                idx = 0;
                for (int k = 1; k <= 4; k++) if (lpat[k] == p_res) idx = k;
                if (idx == 0) begin e_seq = 1; e_state = 0; end
                else if (e_state == 0) e_state = idx;
                else if (idx == e_state) e_state = idx;
                else if (idx == e_state % 4 + 1) e_state = idx;
                else begin e_seq = 1; e_state = 0; end
            end
            h_vld = 1;
            h_sel = p_sel;
        end
        if (clr) begin e_seq = 0; e_cnt = 0; end
        p_vld = 1; p_sel = sel; p_res = result;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge(); else model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0; sel = 0; result = 0; clr = 0;
        model_reset();
        step(); step();
        n_chk++;
        if (dut_bus !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_init: got %h want 0", dut_bus);
        end
        rst = 1;
        step();
        result = 3'd5;
        repeat (6) step();
        sel = 1; result = 3'b111;
        repeat (4) step();
        n_chk++;
        if ({dice_val, seq_err} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_setup: got val=%0d err=%b want 5 1", dice_val, seq_err);
        end
        #2 rst = 0;
        model_reset();
        #1;
        n_chk++;
        if (dut_bus !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", dut_bus);
        end
        sel = 0; result = 0;
        @(negedge clk);
        step();
        rst = 1;
        step();
        n_chk++;
        if (dut_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL reset_restart: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_dice_settle();
        sel = 0; result = 3'd3;
        repeat (8) begin
            step();
            n_chk++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL settle3: got %h want %h", dut_bus, exp_bus());
            end
        end
        n_chk++;
        if ({dice_val, seg, throw_count} !== {3'd3, 7'b1001111, 8'd1}) begin
            n_fail++;
            $display("FAIL settle3_val: got %0d %b %0d want 3 1001111 1",
                     dice_val, seg, throw_count);
        end
        repeat (8) step();
        n_chk++;
        if (throw_count !== 8'd1) begin
            n_fail++;
            $display("FAIL settle_once: got %0d want 1", throw_count);
        end
        result = 3'd4;
        repeat (8) step();
        n_chk++;
        if ({dice_val, throw_count} !== {3'd4, 8'd2}) begin
            n_fail++;
            $display("FAIL settle4: got %0d %0d want 4 2", dice_val, throw_count);
        end
    endtask

    task automatic test_dice_bounce();
        int pulses;
        for (int i = 0; i < 10; i++) begin
            result = (i % 2) ? 3'd5 : 3'd2;
            step();
            n_chk++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL bounce: got %h want %h", dut_bus, exp_bus());
            end
        end
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            result = (i < 4) ? 3'd7 : 3'd6;
            step();
            if (dice_err) pulses++;
            n_chk++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL illegal7: got %h want %h", dut_bus, exp_bus());
            end
        end
        n_chk++;
        if (pulses != 1 || dice_val !== 3'd4 || throw_count !== 8'd2) begin
            n_fail++;
            $display("FAIL dice_err_pulse: got pulses=%0d val=%0d cnt=%0d want 1 4 2",
                     pulses, dice_val, throw_count);
        end
    endtask

    task automatic test_lights_legal();
        int seen[$];
        logic [2:0] prev;
        prev = light_state;
        sel = 1;
        for (int p = 0; p < 5; p++) begin
            result = lpat[(p % 4) + 1];
            repeat ((p == 4) ? 5 : 3) begin
                step();
                if (light_state !== prev) seen.push_back(int'(light_state));
                prev = light_state;
                n_chk++;
                if (dut_bus !== exp_bus() || seq_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lights_legal: got %h want %h", dut_bus, exp_bus());
                end
            end
        end
        n_chk++;
        if (seen.size() != 5 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3 ||
            seen[3] != 4 || seen[4] != 1) begin
            n_fail++;
            $display("FAIL lights_order: got %p want 1 2 3 4 1", seen);
        end
    endtask

    task automatic test_lights_illegal();
        result = 3'b110; repeat (3) step();
        result = 3'b001; repeat (3) step();
        n_chk++;
        if (light_state !== 3'd3) begin
            n_fail++;
            $display("FAIL to_green: got %0d want 3", light_state);
        end
        result = 3'b100;
        step(); step();
        n_chk++;
        if ({light_state, seq_err} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_order: got %0d %b want 0 1", light_state, seq_err);
        end
        step();
        n_chk++;
        if (light_state !== 3'd1) begin
            n_fail++;
            $display("FAIL resync: got %0d want 1", light_state);
        end
        result = 3'b111; repeat (3) step();
        n_chk++;
        if ({light_state, seq_err} !== {3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL pat111: got %0d %b want 0 1", light_state, seq_err);
        end
        result = 3'b100; repeat (3) step();
        clr = 1; step(); clr = 0;
        n_chk++;
        if ({seq_err, throw_count} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL clr: got err=%b cnt=%0d want 0 0", seq_err, throw_count);
        end
        step();
        n_chk++;
        if (dut_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL after_clr: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_switching();
        logic [CNT_W-1:0] c0;
        result = 3'b100;
        sel = 0;
        c0 = throw_count;
        step(); step();
        n_chk++;
        if (throw_count !== c0 || dice_err !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_to_dice: got cnt=%0d err=%b want %0d 0",
                     throw_count, dice_err, c0);
        end
        repeat (6) begin
            step();
            n_chk++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL sw_dice: got %h want %h", dut_bus, exp_bus());
            end
        end
        c0 = throw_count;
        sel = 1;
        step(); step();
        n_chk++;
        if (light_state !== 3'd0 || throw_count !== c0) begin
            n_fail++;
            $display("FAIL blank_to_lights: got st=%0d cnt=%0d want 0 %0d",
                     light_state, throw_count, c0);
        end
        step();
        n_chk++;
        if (light_state !== 3'd1 || throw_count !== c0) begin
            n_fail++;
            $display("FAIL lights_after_blank: got st=%0d want 1", light_state);
        end
        sel = 0;
        repeat (4) begin
            step();
            n_chk++;
            if (throw_count !== c0 || dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL no_spurious: got %h want %h", dut_bus, exp_bus());
            end
        end
    endtask

    task automatic test_saturation();
        clr = 1; step(); clr = 0;
        for (int i = 0; i < 260; i++) begin
            result = (i % 2) ? 3'd2 : 3'd1;
            repeat (5) step();
        end
        n_chk++;
        if (throw_count !== 8'd255 || dut_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL saturate: got %0d want 255", throw_count);
        end
        result = 3'd3;
        repeat (7) step();
        n_chk++;
        if ({dice_val, throw_count} !== {3'd3, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d %0d want 3 255", dice_val, throw_count);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) sel = ~sel;
            if (hold == 0) begin
                if (sel && $urandom_range(0, 9) < 7)
                    result = lpat[$urandom_range(1, 4)];
                else
                    result = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 6);
            end
            hold--;
            clr = ($urandom_range(0, 39) == 0);
            step();
            n_chk++;
            if (dut_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_bus, exp_bus());
            end
        end
        clr = 0;
    endtask

    initial begin
        test_reset();
        test_dice_settle();
        test_dice_bounce();
        test_lights_legal();
        test_lights_illegal();
        test_switching();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
